// File: rtl/i8088_bus_ctrl.sv
// 8088 bus-cycle controller: status decode, T-state sequencer, address/data latches, READY sync.
// Optional wait-state generator compiled in with I8088_BUS_WAIT_GEN_EN.
module i8088_bus_ctrl #(
    parameter int IO_WAIT  = 1,
    parameter int MEM_WAIT = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  S2_S0,
    input  logic [19:0] AD_IN,
    input  logic [7:0]  BUS_DIN,
    input  logic        READY_IN,
    output logic        ALE,
    output logic [19:0] ADDR,
    output logic [7:0]  CPU_DIN,
    output logic        MEMR_N,
    output logic        MEMW_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic        INTA_N,
    output logic        DT_R,
    output logic        DEN,
    output logic        READY_OUT,
    output logic        HALT,
    output logic [2:0]  BUS_CYCLE
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_HLT
    } state_t;

    localparam logic [2:0] ST_INTA = 3'b000;
    localparam logic [2:0] ST_IOR  = 3'b001;
    localparam logic [2:0] ST_IOW  = 3'b010;
    localparam logic [2:0] ST_HALT = 3'b011;
    localparam logic [2:0] ST_CODE = 3'b100;
    localparam logic [2:0] ST_MEMR = 3'b101;
    localparam logic [2:0] ST_MEMW = 3'b110;
    localparam logic [2:0] ST_PASV = 3'b111;

    state_t     state, state_nxt;
    logic [2:0] prev_s;
    logic       start;
    logic       ready_meta, ready_sync, ready_eff;
    logic       active_nxt, is_read, is_write, is_io, in_wait;

    assign start     = (prev_s == ST_PASV) && (S2_S0 != ST_PASV);
    assign is_read   = (BUS_CYCLE == ST_INTA) || (BUS_CYCLE == ST_IOR) ||
                       (BUS_CYCLE == ST_CODE) || (BUS_CYCLE == ST_MEMR);
    assign is_write  = (BUS_CYCLE == ST_IOW) || (BUS_CYCLE == ST_MEMW);
    assign is_io     = (BUS_CYCLE == ST_INTA) || (BUS_CYCLE == ST_IOR) ||
                       (BUS_CYCLE == ST_IOW);
    assign in_wait   = (state == S_T3) || (state == S_TW);
    assign READY_OUT = ready_eff;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_T1;
            S_T1:       state_nxt = (BUS_CYCLE == ST_HALT) ? S_HLT : S_T2;
            S_T2:       state_nxt = S_T3;
            S_T3, S_TW: state_nxt = ready_eff ? S_T4 : S_TW;
            S_T4:       state_nxt = start ? S_T1 : S_IDLE;
            S_HLT:      if (start) state_nxt = S_T1;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Strobes and transceiver controls are asserted for T2 through the last T3/TW.
    assign active_nxt = (state_nxt == S_T2) || (state_nxt == S_T3) || (state_nxt == S_TW);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            prev_s     <= ST_PASV;
            ALE        <= 1'b0;
            ADDR       <= '0;
            CPU_DIN    <= '0;
            MEMR_N     <= 1'b1;
            MEMW_N     <= 1'b1;
            IOR_N      <= 1'b1;
            IOW_N      <= 1'b1;
            INTA_N     <= 1'b1;
            DT_R       <= 1'b0;
            DEN        <= 1'b0;
            HALT       <= 1'b0;
            BUS_CYCLE  <= ST_PASV;
        end else begin
            state  <= state_nxt;
            prev_s <= S2_S0;
            ALE    <= (state_nxt == S_T1);
            HALT   <= (state_nxt == S_HLT);
            if (state_nxt == S_T1)
                BUS_CYCLE <= S2_S0;
            if (state == S_T1)
                ADDR <= AD_IN;
            if (in_wait && (state_nxt == S_T4) && is_read)
                CPU_DIN <= BUS_DIN;
            MEMR_N <= !(active_nxt && ((BUS_CYCLE == ST_CODE) || (BUS_CYCLE == ST_MEMR)));
            MEMW_N <= !(active_nxt && (BUS_CYCLE == ST_MEMW));
            IOR_N  <= !(active_nxt && (BUS_CYCLE == ST_IOR));
            IOW_N  <= !(active_nxt && (BUS_CYCLE == ST_IOW));
            INTA_N <= !(active_nxt && (BUS_CYCLE == ST_INTA));
            DEN    <= active_nxt;
            DT_R   <= active_nxt && is_write;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ready_meta <= 1'b0;
            ready_sync <= 1'b0;
        end else begin
            ready_meta <= READY_IN;
            ready_sync <= ready_meta;
        end
    end

`ifdef I8088_BUS_WAIT_GEN_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            wait_cnt <= '0;
        else if ((state == S_T1) && (state_nxt == S_T2))
            wait_cnt <= is_io ? 8'(IO_WAIT) : 8'(MEM_WAIT);
        else if (in_wait && (wait_cnt != '0))
            wait_cnt <= wait_cnt - 8'd1;
    end

    assign ready_eff = ready_sync && (wait_cnt == '0);
`else
    assign ready_eff = ready_sync;
`endif

endmodule

// File: tb/tb_i8088_bus_ctrl.sv
// Directed bench for i8088_bus_ctrl; honours I8088_BUS_WAIT_GEN_EN (default IO_WAIT=1, MEM_WAIT=0).
module tb_i8088_bus_ctrl;

`ifdef I8088_BUS_WAIT_GEN_EN
    localparam int IO_EXTRA = 1;
`else
    localparam int IO_EXTRA = 0;
`endif

    logic        CLK, RESET, READY_IN;
    logic [2:0]  S2_S0;
    logic [19:0] AD_IN;
    logic [7:0]  BUS_DIN;
    logic        ALE, MEMR_N, MEMW_N, IOR_N, IOW_N, INTA_N, DT_R, DEN, READY_OUT, HALT;
    logic [19:0] ADDR;
    logic [7:0]  CPU_DIN;
    logic [2:0]  BUS_CYCLE;

    int n_pass  = 0;
    int n_total = 0;
    int n_low;

    i8088_bus_ctrl #(.IO_WAIT(1), .MEM_WAIT(0)) dut (
        .CLK(CLK), .RESET(RESET), .S2_S0(S2_S0), .AD_IN(AD_IN), .BUS_DIN(BUS_DIN),
        .READY_IN(READY_IN), .ALE(ALE), .ADDR(ADDR), .CPU_DIN(CPU_DIN),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .INTA_N(INTA_N),
        .DT_R(DT_R), .DEN(DEN), .READY_OUT(READY_OUT), .HALT(HALT), .BUS_CYCLE(BUS_CYCLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Strobe vector {MEMR_N, MEMW_N, IOR_N, IOW_N, INTA_N}
    function automatic logic [4:0] strobes();
        return {MEMR_N, MEMW_N, IOR_N, IOW_N, INTA_N};
    endfunction

    function automatic logic pick(input int w);
        logic [4:0] s;
        s = strobes();
        return s[w];
    endfunction

    // Counts consecutive low cycles of strobe bit w, starting at a cycle where it is low.
    task automatic count_low(input int w, output int n);
        n = 0;
        while (pick(w) === 1'b0 && n < 12) begin
            n++;
            tick();
        end
    endtask

    initial begin
        RESET = 1'b1; S2_S0 = 3'b111; AD_IN = '0; BUS_DIN = '0; READY_IN = 1'b1;
        #12;
        check("rst_strobes", 32'(strobes()), 32'h1f);
        check("rst_ale", 32'(ALE), 0);
        check("rst_den_dtr", 32'({DEN, DT_R}), 0);
        check("rst_addr", 32'(ADDR), 0);
        check("rst_cpudin", 32'(CPU_DIN), 0);
        check("rst_bus_cycle", 32'(BUS_CYCLE), 32'h7);
        check("rst_halt_rdy", 32'({HALT, READY_OUT}), 0);
        tick();
        RESET = 1'b0;
        tick();
        check("ready_latency_1clk", 32'(READY_OUT), 0);
        tick();
        check("ready_latency_2clk", 32'(READY_OUT), 1);

        // Zero-wait memory read
        S2_S0 = 3'b101; AD_IN = 20'hFFFF0; BUS_DIN = 8'hEA;
        tick();
        check("memr_t1_ale", 32'(ALE), 1);
        check("memr_t1_bc", 32'(BUS_CYCLE), 32'h5);
        check("memr_t1_nostrobe", 32'(strobes()), 32'h1f);
        S2_S0 = 3'b111;
        tick();
        check("memr_t2_ale", 32'(ALE), 0);
        check("memr_t2_addr", 32'(ADDR), 32'hFFFF0);
        check("memr_t2_strobes", 32'(strobes()), 32'h0f);
        check("memr_t2_den_dtr", 32'({DEN, DT_R}), 32'h2);
        tick();
        check("memr_t3_memr", 32'(MEMR_N), 0);
        tick();
        check("memr_t4_memr", 32'(MEMR_N), 1);
        check("memr_t4_den", 32'(DEN), 0);
        check("memr_cpudin", 32'(CPU_DIN), 32'hEA);
        tick();

        // I/O write stretched by slot READY
        S2_S0 = 3'b010; AD_IN = 20'h00378; BUS_DIN = 8'h11;
        tick();
        check("iow_t1_bc", 32'(BUS_CYCLE), 32'h2);
        S2_S0 = 3'b111; READY_IN = 1'b0;
        tick();
        check("iow_t2_strobes", 32'(strobes()), 32'h1d);
        check("iow_t2_dtr", 32'(DT_R), 1);
        check("iow_t2_addr", 32'(ADDR), 32'h00378);
        tick();
        check("iow_t3_rdy", 32'(READY_OUT), 0);
        tick();
        check("iow_tw1", 32'({IOW_N, DT_R, DEN, READY_OUT}), 32'h6);
        READY_IN = 1'b1;
        tick();
        check("iow_tw2", 32'({IOW_N, DT_R, DEN, READY_OUT}), 32'h6);
        tick();
        check("iow_tw3_low", 32'(IOW_N), 0);
        tick();
        check("iow_t4_strobes", 32'(strobes()), 32'h1f);
        check("iow_t4_den_dtr", 32'({DEN, DT_R}), 0);
        check("iow_no_latch", 32'(CPU_DIN), 32'hEA);
        tick();

        // I/O read: zero slot wait, plus generator waits when compiled in
        S2_S0 = 3'b001; AD_IN = 20'h003F8; BUS_DIN = 8'h5A;
        tick();
        S2_S0 = 3'b111;
        tick();
        check("ior_t2_strobes", 32'(strobes()), 32'h1b);
        count_low(2, n_low);
        check("ior_low_cycles", 32'(n_low), 32'(2 + IO_EXTRA));
        check("ior_cpudin", 32'(CPU_DIN), 32'h5A);
        tick();

        // HALT then restart with a memory read
        S2_S0 = 3'b011; AD_IN = 20'h12345;
        tick();
        check("hlt_t1_ale", 32'(ALE), 1);
        S2_S0 = 3'b111;
        tick();
        check("hlt_halt", 32'(HALT), 1);
        check("hlt_nostrobe", 32'({strobes(), DEN, ALE}), 32'h7c);
        check("hlt_addr", 32'(ADDR), 32'h12345);
        tick();
        check("hlt_hold", 32'(HALT), 1);
        S2_S0 = 3'b101; BUS_DIN = 8'h77;
        tick();
        check("hlt_exit", 32'({HALT, ALE}), 32'h1);
        check("hlt_exit_bc", 32'(BUS_CYCLE), 32'h5);
        S2_S0 = 3'b111;
        tick();
        count_low(4, n_low);
        check("hlt_memr_low", 32'(n_low), 2);
        check("hlt_memr_cpudin", 32'(CPU_DIN), 32'h77);
        tick();

        // Back-to-back INTA cycles
        S2_S0 = 3'b000; BUS_DIN = 8'hFF;
        tick();
        check("inta1_bc", 32'(BUS_CYCLE), 0);
        tick();
        check("inta1_strobes", 32'(strobes()), 32'h1e);
        S2_S0 = 3'b111;
        count_low(0, n_low);
        check("inta1_low", 32'(n_low), 32'(2 + IO_EXTRA));
        check("inta1_cpudin", 32'(CPU_DIN), 32'hFF);
        S2_S0 = 3'b000; BUS_DIN = 8'h08;
        tick();
        check("inta2_no_idle_ale", 32'(ALE), 1);
        tick();
        check("inta2_strobe", 32'(INTA_N), 0);
        S2_S0 = 3'b111;
        count_low(0, n_low);
        check("inta2_low", 32'(n_low), 32'(2 + IO_EXTRA));
        check("inta2_vector", 32'(CPU_DIN), 32'h08);
        tick();

        // Asynchronous reset during a wait state
        S2_S0 = 3'b001; READY_IN = 1'b0;
        tick();
        S2_S0 = 3'b111;
        tick();
        tick();
        tick();
        check("rtw_in_wait", 32'({IOR_N, DEN}), 32'h1);
        #2 RESET = 1'b1;
        #1;
        check("rtw_strobes", 32'(strobes()), 32'h1f);
        check("rtw_den_bc", 32'({DEN, BUS_CYCLE}), 32'h7);
        check("rtw_addr_din", 32'({ADDR, CPU_DIN}), 0);
        tick();
        RESET = 1'b0; READY_IN = 1'b1;
        tick();
        tick();
        check("rtw_idle_after", 32'({strobes(), ALE}), 32'h3e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i8088_bus_ctrl.md
# i8088_bus_ctrl

Bus-cycle controller directly downstream of the 8088 core: samples the CPU status lines (S2..S0) and the multiplexed address bus, and runs the T1/T2/T3/Tw/T4 cycle state machine. Outputs are ALE, the latched 20-bit address, active-low command strobes, transceiver controls, the read-data latch returned to the CPU, and the synchronised READY fed back to the CPU. It replaces an external 8288 + address latches + 8284 READY logic inside the PCXT core.

## Interface
Parameters:
- IO_WAIT, 1, wait states added to I/O and INTA cycles (used only with the wait generator compiled in)
- MEM_WAIT, 0, wait states added to memory cycles (same condition)

Ports:
- CLK  in  1  bus clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- S2_S0  in  3  CPU status (000 INTA, 001 IOR, 010 IOW, 011 HALT, 100 CODE, 101 MEMR, 110 MEMW, 111 passive)
- AD_IN  in  20  CPU multiplexed address/data output
- BUS_DIN  in  8  read data from memory/IO/PIC
- READY_IN  in  1  asynchronous ready from slots, high = ready
- ALE  out  1  address latch enable
- ADDR  out  20  latched address
- CPU_DIN  out  8  read data latched for CPU
- MEMR_N, MEMW_N, IOR_N, IOW_N, INTA_N  out  1 each  command strobes
- DT_R  out  1  1 = transmit (write), 0 = receive
- DEN  out  1  data enable
- READY_OUT  out  1  synchronised ready to CPU
- HALT  out  1  CPU halted
- BUS_CYCLE  out  3  status latched at cycle start

## Operation
- prev_s = S2_S0 registered each CLK; start = (prev_s == 111) && (S2_S0 != 111).
- States: IDLE, T1, T2, T3, TW, T4, HLT.
- IDLE: start → T1, latch S2_S0 into BUS_CYCLE.
- T1: ALE = 1; ADDR latched from AD_IN at end of T1. Status 011 → HLT next; otherwise T2.
- T2: the strobe selected by BUS_CYCLE goes low (CODE and MEMR both use MEMR_N). DEN = 1. DT_R = 1 for IOW/MEMW, else 0.
- T3: if ready_eff → T4, else TW.
- TW: repeat until ready_eff → T4.
- On the T3/TW→T4 edge, a read or INTA latches BUS_DIN into CPU_DIN.
- T4: strobes high, DEN = 0. Next state is T1 if start, else IDLE.
- HLT: HALT = 1, no strobes. start → T1 and HALT clears.
- ready_sync: READY_IN through two flops.
- ready_eff = ready_sync && (wait counter == 0). Without the wait generator, ready_eff = ready_sync.
- READY_OUT = ready_eff.
- Only one strobe is ever low at a time.
- INTA: each of the two CPU INTA cycles is an independent bus cycle.

## Timing
- Reset values: state IDLE, prev_s = 111, ALE 0, ADDR 0, CPU_DIN 0, all *_N 1, DT_R 0, DEN 0, READY_OUT 0, HALT 0, BUS_CYCLE 111, wait counter 0.
- RESET asserted mid-cycle forces these values asynchronously; no partial strobe survives.
- All outputs are registered.
- start sampled at edge n: ALE high cycle n+1, strobe low cycles n+2 through the last T3/TW. Zero-wait read is 4 CLK from ALE to strobe release.
- READY_IN latency: 2 CLK to ready_sync. A READY_IN deassert must arrive ≥2 CLK before T3 to insert a wait.
- Back-to-back: start during T4 → T1 on the next edge, no IDLE gap.
- Status change during T2..TW (other than to 111) is ignored until the next start.

## Configuration
- I8088_BUS_WAIT_GEN_EN defined: the wait counter loads IO_WAIT (IOR/IOW/INTA) or MEM_WAIT (others) on entry to T2, and decrements in T3/TW while nonzero. ready_eff requires counter == 0 and ready_sync.
- Undefined: counter logic removed; ready_eff = ready_sync; IO_WAIT/MEM_WAIT ignored.

## Test plan
- Reset: RESET pulse mid-TW → all strobes 1, DEN 0, state IDLE, BUS_CYCLE 111 same cycle.
- MEMR zero-wait: S2_S0 111→101, AD_IN 0xFFFF0, READY_IN 1 → ADDR 0xFFFF0; MEMR_N low exactly 2 CLK; CPU_DIN = BUS_DIN (0xEA) sampled at T4 entry.
- IOW with slot wait: S2_S0 →010, READY_IN low 3 CLK over T3 → IOW_N low through 3 TW; DT_R 1; READY_OUT 0 during TW.
- Macro enabled, IO_WAIT=1, IOR → exactly one TW with READY_IN 1; MEMR with MEM_WAIT=0 → no TW.
- HALT: S2_S0 →011 → ALE pulse, no strobe, HALT 1 until next start (101), then T1.
- Back-to-back: INTA, passive in T3, second INTA start in T4 → two INTA_N pulses, no IDLE cycle between; CPU_DIN = vector 0x08 after the second pulse.
